// File: rtl/nibble_sort_controller.sv
// Sorts the four nibbles of a 16-bit word with a fixed six-step bubble schedule.
// A single shared magnitude comparator makes one compare per cycle.

module four_bit_comparator (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       G,
  output logic       E,
  output logic       L
);
  assign G = (A > B);
  assign E = (A == B);
  assign L = (A < B);
endmodule

module nibble_sort_controller #(
  parameter bit ASCENDING = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        busy,
  output logic        done,
  output logic [2:0]  swap_count
);
  typedef enum logic [1:0] {IDLE = 2'd0, SORT = 2'd1, DONE = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [3:0][3:0] w, w_swp;
  logic [1:0]      pass, j, j1;
  logic [2:0]      cnt, cnt_nxt;
  logic            a_gt, a_eq, a_lt;
  logic            swap, last;

  assign j1 = j + 2'd1;

  four_bit_comparator u_cmp (
    .A (w[j]),
    .B (w[j1]),
    .G (a_gt),
    .E (a_eq),
    .L (a_lt)
  );

  // Equal nibbles never move, which keeps the sort stable.
  assign swap    = !a_eq && (ASCENDING ? a_gt : a_lt);
  assign last    = (pass == 2'd2);
  assign cnt_nxt = cnt + {2'b00, swap};
  assign busy    = (state == SORT);
  assign done    = (state == DONE);

  always_comb begin
    w_swp = w;
    if (swap) begin
      w_swp[j]  = w[j1];
      w_swp[j1] = w[j];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SORT;
      SORT:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w          <= '0;
      cnt        <= '0;
      pass       <= '0;
      j          <= '0;
      data_out   <= '0;
      swap_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            w    <= data_in;
            cnt  <= '0;
            pass <= '0;
            j    <= '0;
          end
        end
        SORT: begin
          w   <= w_swp;
          cnt <= cnt_nxt;
          // Pass p covers j = 0 .. 2-p.
          if (j == 2'd2 - pass) begin
            pass <= pass + 2'd1;
            j    <= '0;
          end else begin
            j <= j + 2'd1;
          end
          if (last) begin
            data_out   <= w_swp;
            swap_count <= cnt_nxt;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/nibble_sort_controller.md
NIBBLE_SORT_CONTROLLER -- requirements
Module: nibble_sort_controller

Interface
REQ-001 The block SHALL have parameter ASCENDING, default 1, selecting the order: 1 = nibble 0 smallest, 0 = nibble 0 largest.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, the reset; it is asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit, a request to sort data_in, sampled only in IDLE.
REQ-005 The block SHALL have port data_in, input, 16 bits, four unsigned nibbles; nibble k = bits [4k+3:4k].
REQ-006 The block SHALL have port data_out, output, 16 bits, the last sorted result, same nibble packing.
REQ-007 The block SHALL have port busy, output, 1 bit, high in LOAD-to-SORT operation (state SORT).
REQ-008 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking data_out/swap_count valid.
REQ-009 The block SHALL have port swap_count, output, 3 bits, the number of swaps performed in the last sort (0..6).

Function
REQ-010 The block SHALL contain exactly one instance of four_bit_comparator (ports A, B, G, E, L), shared across all compare steps; no other magnitude compare of data nibbles is permitted.
REQ-011 The FSM SHALL have states IDLE, SORT and DONE; encoding is free.
REQ-012 In IDLE with start=1 at a rising edge, the block SHALL load data_in into working registers w0..w3, clear the swap counter, set pass=0, j=0 and enter SORT.
REQ-013 In SORT, the comparator SHALL see A = w[j], B = w[j+1] combinationally; one compare per cycle.
REQ-014 When ASCENDING=1 and G=1, or ASCENDING=0 and L=1, the block SHALL swap w[j] and w[j+1] at the next edge and increment the swap counter; when E=1 it SHALL never swap, so the sort is stable.
REQ-015 The compare schedule SHALL be bubble order (pass, j): (0,0) (0,1) (0,2) (1,0) (1,1) (2,0), i.e. 6 SORT cycles, fixed regardless of data.
REQ-016 At the edge ending compare (2,0), the block SHALL copy the final w0..w3 to data_out and the counter to swap_count, and enter DONE.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-018 Latency: with start sampled at edge k, done SHALL be high in the cycle following edge k+6 and low at all other times.
REQ-019 start in SORT or DONE SHALL be ignored; it has no effect on the working registers, counter or outputs.
REQ-020 start held high continuously SHALL begin a new sort on each IDLE visit, giving one result every 8 cycles.
REQ-021 busy SHALL equal 1 exactly in SORT.
REQ-022 data_out and swap_count SHALL hold their values between done pulses.
REQ-023 data_in SHALL be sampled only at the start edge; later changes SHALL not affect the current sort.

Reset
REQ-024 rst=1 SHALL immediately, independent of clk, force state IDLE, and force data_out=16'h0000, swap_count=0, busy=0, done=0 and w0..w3=0.
REQ-025 rst asserted during SORT or DONE SHALL abort the sort with no done pulse; the first start after rst deasserts SHALL begin a fresh sort.

Verification
REQ-026 The bench SHALL cover these scenarios: ASCENDING=1, data_in=16'h1234 -> data_out=16'h4321, swap_count=6, done 7 cycles after the start edge.
REQ-027 The bench SHALL cover: ASCENDING=1, data_in=16'h4321 (already sorted) -> data_out=16'h4321, swap_count=0.
REQ-028 The bench SHALL cover: ASCENDING=1, data_in=16'h5A5A (duplicates) -> data_out=16'hAA55, swap_count=3.
REQ-029 The bench SHALL cover: ASCENDING=0, data_in=16'h4321 -> data_out=16'h1234, swap_count=6.
REQ-030 The bench SHALL cover: start pulsed again 3 cycles after the first start (data_in=16'hFFFF) -> ignored; first result is unchanged and exactly one done pulse occurs.
REQ-031 The bench SHALL cover: rst asserted mid-SORT -> all outputs 0 at once, no done pulse; the next start with 16'h1234 -> 16'h4321.
REQ-032 The bench SHALL cover 15 random data_in values, checking data_out against a reference model and swap_count against the inversion count.
